msg_uart_tx: RTL and testbench

- Downstream of the telephone FSM. Consumes the 64-bit statusMsg and sentMsg ASCII buses, each holding 8 characters with byte [63:56] as the leftmost character.
- Serialises them as a text line over an 8N1 UART so a terminal or host shows the phone display.
- Sends a new frame whenever either bus changes, or on request.

---
 rtl/msg_uart_pkg.sv | 37 +++
 rtl/msg_uart_tx_byte.sv | 129 ++++++++++++
 rtl/msg_uart_tx.sv | 81 ++++++++
 tb/tb_msg_uart_tx.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/msg_uart_pkg.sv
// Shared state type, ASCII constants and frame byte selection for msg_uart_tx.
// Defining MSG_UART_PARITY_EN adds the PARITY state.
package msg_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef MSG_UART_PARITY_EN
        PARITY,
`endif
        STOP
    } uart_state_t;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    localparam int FRAME_BYTES = 18;
    localparam int MSG_BYTES   = 8;

    localparam logic [4:0] LAST_BYTE = 5'(FRAME_BYTES - 1);

    // Byte idx of the line: 16 message characters (leftmost first), then CR, then LF.
    function automatic logic [7:0] frame_byte(input logic [127:0] frame, input logic [4:0] idx);
        logic [127:0] shifted;
        shifted = frame << {idx, 3'b000};
        if (idx < 5'(2 * MSG_BYTES)) begin
            return shifted[127:120];
        end else if (idx == 5'(2 * MSG_BYTES)) begin
            return ASCII_CR;
        end else begin
            return ASCII_LF;
        end
    endfunction

endpackage

// File: rtl/msg_uart_tx_byte.sv
// Serialises one byte as start, 8 data bits LSB first, optional even parity
// (MSG_UART_PARITY_EN) and stop. done marks the final cycle of the stop bit.
module uart_byte_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int BAUD_CNT_W   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);
    import msg_uart_pkg::*;

    localparam logic [BAUD_CNT_W-1:0] BAUD_LAST = BAUD_CNT_W'(CLKS_PER_BIT - 1);

    uart_state_t           state;
    uart_state_t           next_state;
    logic [BAUD_CNT_W-1:0] baud_cnt;
    logic [3:0]            bit_cnt;
    logic [7:0]            shreg;
    logic                  tx_next;
    logic                  load;
    logic                  baud_end;
`ifdef MSG_UART_PARITY_EN
    logic                  parity_q;
`endif

    assign baud_end = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
`ifdef MSG_UART_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state <= next_state;
            tx    <= tx_next;
            if (load) begin
                shreg    <= data;
                baud_cnt <= '0;
                bit_cnt  <= '0;
`ifdef MSG_UART_PARITY_EN
                parity_q <= ^data;
`endif
            end else if (state != IDLE) begin
                if (baud_end) begin
                    baud_cnt <= '0;
                    if (state == DATA) begin
                        shreg   <= {1'b0, shreg[7:1]};
                        bit_cnt <= (bit_cnt == 4'd7) ? 4'd0 : bit_cnt + 4'd1;
                    end
                end else begin
                    baud_cnt <= baud_cnt + 1'b1;
                end
            end
        end
    end

    // A start request during the last stop cycle chains the next byte with no idle gap.
    always_comb begin
        next_state = state;
        tx_next    = tx;
        load       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = START;
                    load       = 1'b1;
                    tx_next    = 1'b0;
                end
            end
            START: begin
                if (baud_end) begin
                    next_state = DATA;
                    tx_next    = shreg[0];
                end
            end
            DATA: begin
                if (baud_end) begin
                    if (bit_cnt == 4'd7) begin
`ifdef MSG_UART_PARITY_EN
                        next_state = PARITY;
                        tx_next    = parity_q;
`else
                        next_state = STOP;
                        tx_next    = 1'b1;
`endif
                    end else begin
                        tx_next = shreg[1];
                    end
                end
            end
`ifdef MSG_UART_PARITY_EN
            PARITY: begin
                if (baud_end) begin
                    next_state = STOP;
                    tx_next    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_end) begin
                    done = 1'b1;
                    if (start) begin
                        next_state = START;
                        load       = 1'b1;
                        tx_next    = 1'b0;
                    end else begin
                        next_state = IDLE;
                        tx_next    = 1'b1;
                    end
                end
            end
            default: begin
                next_state = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/msg_uart_tx.sv
// Sends statusMsg and sentMsg as an 18-byte text line (16 chars + CR LF) over a UART
// whenever they change or resend pulses. MSG_UART_PARITY_EN enables even parity.
module msg_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int BAUD_CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] statusMsg,
    input  logic [63:0] sentMsg,
    input  logic        resend,
    output logic        tx,
    output logic        busy,
    output logic        frame_done
);
    import msg_uart_pkg::*;

    logic [127:0] cur_msg;
    logic [127:0] frame_buf;
    logic [127:0] last_sent;
    logic [4:0]   byte_idx;
    logic         trigger;
    logic         byte_start;
    logic [7:0]   byte_data;
    logic         byte_done;

    assign cur_msg = {statusMsg, sentMsg};
    assign trigger = !busy && ((cur_msg != last_sent) || resend);

    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= 1'b0;
            frame_done <= 1'b0;
            byte_idx   <= '0;
            frame_buf  <= {(2 * MSG_BYTES){ASCII_SPACE}};
            last_sent  <= {(2 * MSG_BYTES){ASCII_SPACE}};
        end else begin
            frame_done <= 1'b0;
            if (!busy) begin
                if (trigger) begin
                    frame_buf <= cur_msg;
                    last_sent <= cur_msg;
                    busy      <= 1'b1;
                    byte_idx  <= '0;
                end
            end else if (byte_done) begin
                if (byte_idx == LAST_BYTE) begin
                    busy       <= 1'b0;
                    frame_done <= 1'b1;
                end else begin
                    byte_idx <= byte_idx + 5'd1;
                end
            end
        end
    end

    // The first byte comes straight from the inputs because the buffer loads on the same edge.
    always_comb begin
        byte_start = 1'b0;
        byte_data  = cur_msg[127:120];
        if (!busy) begin
            byte_start = trigger;
        end else begin
            byte_start = byte_done && (byte_idx != LAST_BYTE);
            byte_data  = frame_byte(frame_buf, byte_idx + 5'd1);
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .BAUD_CNT_W  (BAUD_CNT_W)
    ) u_byte_tx (
        .clk  (clk),
        .rst  (rst),
        .start(byte_start),
        .data (byte_data),
        .tx   (tx),
        .done (byte_done)
    );

endmodule

// File: tb/tb_msg_uart_tx.sv
// Directed bench for msg_uart_tx: a UART decoder pops expected bytes from a scoreboard
// queue filled when stimulus is applied. MSG_UART_PARITY_EN selects 8E1 framing.
module tb_msg_uart_tx;

    localparam int CPB = 4;
    localparam int BCW = 4;
`ifdef MSG_UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_CYC = 18 * NBITS * CPB;
    localparam logic [63:0] SPACES = {8{8'h20}};

    logic        clk;
    logic        rst;
    logic [63:0] statusMsg;
    logic [63:0] sentMsg;
    logic        resend;
    logic        tx;
    logic        busy;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    msg_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .BAUD_CNT_W  (BCW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .statusMsg (statusMsg),
        .sentMsg   (sentMsg),
        .resend    (resend),
        .tx        (tx),
        .busy      (busy),
        .frame_done(frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [63:0] s, input logic [63:0] m, input bit expect_frame);
        statusMsg = s;
        sentMsg   = m;
        if (expect_frame) begin
            for (int i = 0; i < 8; i++) exp_q.push_back(s[63 - 8 * i -: 8]);
            for (int i = 0; i < 8; i++) exp_q.push_back(m[63 - 8 * i -: 8]);
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    task automatic wait_frame_done(output int cyc);
        cyc = 0;
        while (cyc < 3 * FRAME_CYC) begin
            @(negedge clk);
            cyc++;
            if (frame_done === 1'b1) return;
        end
        check_output("frame_done_timeout", frame_done, 1);
    endtask

    task automatic observe_idle(input int n, output bit saw_low, output bit saw_busy, output bit saw_done);
        saw_low  = 1'b0;
        saw_busy = 1'b0;
        saw_done = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (tx !== 1'b1) saw_low = 1'b1;
            if (busy !== 1'b0) saw_busy = 1'b1;
            if (frame_done !== 1'b0) saw_done = 1'b1;
        end
    endtask

    // Decodes each UART byte by sampling mid-bit; a reset abandons the byte in flight.
    initial begin : uart_monitor
        logic [10:0] bits;
        logic [7:0]  data;
        bit          ab;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0 || tx !== 1'b0) continue;
            ab   = 1'b0;
            bits = '0;
            for (int c = 1; c <= 2 + CPB * (NBITS - 1); c++) begin
                @(negedge clk);
                if (rst !== 1'b0) begin
                    ab = 1'b1;
                    break;
                end
                if (c >= 2 && ((c - 2) % CPB) == 0) bits[(c - 2) / CPB] = tx;
            end
            if (!ab) begin
                data = bits[8:1];
                check_output("start_bit", bits[0], 0);
                check_output("stop_bit", bits[NBITS - 1], 1);
`ifdef MSG_UART_PARITY_EN
                check_output("parity_bit", bits[9], ^data);
`endif
                if (exp_q.size() == 0) check_output("unexpected_byte", data, 32'h100);
                else check_output("rx_byte", data, exp_q.pop_front());
            end
        end
    end

    initial begin : stimulus
        int cyc;
        bit saw_low, saw_busy, saw_done;
        rst    = 1'b1;
        resend = 1'b0;
        apply_stimulus("IDLE    ", SPACES, 1'b0);

        repeat (3) @(negedge clk);
        check_output("reset_tx", tx, 1);
        check_output("reset_busy", busy, 0);
        check_output("reset_frame_done", frame_done, 0);

        // First frame right after reset release.
        apply_stimulus("IDLE    ", SPACES, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        check_output("first_tx_fall", tx, 0);
        check_output("first_busy", busy, 1);
        wait_frame_done(cyc);
        check_output("first_len", cyc, FRAME_CYC);
        check_output("first_busy_drop", busy, 0);
        @(negedge clk);
        check_output("first_done_pulse", frame_done, 0);
        check_output("first_queue_empty", exp_q.size(), 0);

        // Unchanged inputs must stay silent.
        observe_idle(1000, saw_low, saw_busy, saw_done);
        check_output("steady_tx", saw_low, 0);
        check_output("steady_busy", saw_busy, 0);
        check_output("steady_done", saw_done, 0);

        // Changes and resend during a frame: only the latest value follows.
        apply_stimulus("MENU    ", SPACES, 1'b1);
        @(negedge clk);
        check_output("menu_start", tx, 0);
        repeat (60) @(negedge clk);
        apply_stimulus("RINGING ", SPACES, 1'b0);
        repeat (60) @(negedge clk);
        resend = 1'b1;
        @(negedge clk);
        resend = 1'b0;
        repeat (60) @(negedge clk);
        apply_stimulus("CALLER  ", SPACES, 1'b1);
        wait_frame_done(cyc);
        @(negedge clk);
        check_output("followup_start", tx, 0);
        check_output("followup_busy", busy, 1);
        repeat (100) @(negedge clk);
        resend = 1'b1;
        @(negedge clk);
        resend = 1'b0;
        wait_frame_done(cyc);
        check_output("followup_len", cyc + 101, FRAME_CYC);
        observe_idle(800, saw_low, saw_busy, saw_done);
        check_output("no_extra_frame", saw_busy, 0);
        check_output("followup_queue_empty", exp_q.size(), 0);

        // resend with unchanged inputs repeats the line.
        apply_stimulus(statusMsg, sentMsg, 1'b1);
        resend = 1'b1;
        @(negedge clk);
        resend = 1'b0;
        check_output("resend_start", tx, 0);
        wait_frame_done(cyc);
        check_output("resend_len", cyc, FRAME_CYC);
        observe_idle(50, saw_low, saw_busy, saw_done);
        check_output("resend_single", saw_busy, 0);
        check_output("resend_queue_empty", exp_q.size(), 0);

        // Reset 50 cycles into a frame aborts it; last_sent returns to spaces.
        apply_stimulus(statusMsg, "HELLO   ", 1'b1);
        @(negedge clk);
        check_output("abort_frame_start", tx, 0);
        repeat (49) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_output("abort_tx", tx, 1);
        check_output("abort_busy", busy, 0);
        @(negedge clk);
        exp_q.delete();
        apply_stimulus(statusMsg, sentMsg, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        check_output("post_reset_start", tx, 0);
        check_output("post_reset_busy", busy, 1);
        wait_frame_done(cyc);
        check_output("post_reset_len", cyc, FRAME_CYC);
        repeat (5) @(negedge clk);
        check_output("post_reset_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
